// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: opcode/funct encodings,
// ALU control codes, the E-stage control payload and the MDU sequencer states.
package pipe_ctrl_pkg;

   localparam int unsigned ALU_W = 4;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type funct codes
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_MFHI = 6'b010000;
   localparam logic [5:0] FN_MFLO = 6'b010010;
   localparam logic [5:0] FN_MULT = 6'b011000;
   localparam logic [5:0] FN_DIV  = 6'b011010;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   typedef enum logic [ALU_W-1:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_XOR = 4'b0011,
      ALU_SLL = 4'b0100,
      ALU_SRL = 4'b0101,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_NOR = 4'b1000,
      ALU_LUI = 4'b1001
   } alu_t;

   // Controls carried from Decode into the E register
   typedef struct packed {
      logic       alusrc;
      logic       regdst;
      logic       regwrite;
      logic       memtoreg;
      logic       memwrite;
      alu_t       alu;
      logic       mdustart;
      logic       mduop;
      logic [1:0] hiloread;
   } ctrl_e_t;

   typedef enum logic {
      MDU_IDLE = 1'b0,
      MDU_BUSY = 1'b1
   } mdu_state_t;

endpackage

// File: rtl/pipe_controller_if.sv
// Control bus between the hazard unit/datapath and pipe_controller.
// master: hazard/datapath side (drives instruction fields, equalD, stallE, flushE)
// slave : controller side (drives all decode and stage controls)
interface pipe_controller_if #(
   parameter int unsigned ALUCTRL_W = 4
);
   logic [5:0]           opD;
   logic [5:0]           functD;
   logic                 equalD;
   logic                 stallE;
   logic                 flushE;
   logic                 pcsrcD;
   logic [1:0]           branchD;
   logic [2:0]           jumpD;
   logic                 immextD;
   logic                 illegalD;
   logic                 mdustallD;
   logic                 alusrcE;
   logic                 regdstE;
   logic                 regwriteE;
   logic                 memtoregE;
   logic [ALUCTRL_W-1:0] alucontrolE;
   logic                 mdustartE;
   logic                 mduopE;
   logic [1:0]           hiloreadE;
   logic                 regwriteM;
   logic                 memtoregM;
   logic                 memwriteM;
   logic                 regwriteW;
   logic                 memtoregW;

   modport master (
      output opD, functD, equalD, stallE, flushE,
      input  pcsrcD, branchD, jumpD, immextD, illegalD, mdustallD,
      input  alusrcE, regdstE, regwriteE, memtoregE, alucontrolE,
      input  mdustartE, mduopE, hiloreadE,
      input  regwriteM, memtoregM, memwriteM, regwriteW, memtoregW
   );

   modport slave (
      input  opD, functD, equalD, stallE, flushE,
      output pcsrcD, branchD, jumpD, immextD, illegalD, mdustallD,
      output alusrcE, regdstE, regwriteE, memtoregE, alucontrolE,
      output mdustartE, mduopE, hiloreadE,
      output regwriteM, memtoregM, memwriteM, regwriteW, memtoregW
   );
endinterface

// File: rtl/pipe_controller_mdu_seq.sv
// mdu_seq: multiply/divide sequencer. Tracks an issued MULT/DIV until its
// HI/LO result is ready and stalls any dependent MDU instruction in Decode.
// Ports: clk, reset (async, active-high), start (mdustartE), stall (stallE),
//        mdu_d (Decode holds MULT/DIV/MFHI/MFLO), mdustall_c (combinational stall).
module mdu_seq
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MDU_LAT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic stall,
   input  logic mdu_d,
   output logic mdustall_c
);
   localparam int unsigned CNT_W = $clog2(MDU_LAT + 1);

   mdu_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic             issue;

   assign issue = start & ~stall;

   // The issue cycle itself counts as a stall cycle, so a dependent op in
   // Decode is held for MDU_LAT-1 cycles and reaches E with the result.
   assign mdustall_c = mdu_d & ((state == MDU_BUSY) | issue);

   // Sequencer FSM and down-counter; flushE is deliberately not an input.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= MDU_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            MDU_IDLE: begin
               if (issue) begin
                  cnt <= CNT_W'(MDU_LAT - 1);
                  if (MDU_LAT > 2) state <= MDU_BUSY;
               end
            end
            MDU_BUSY: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(2)) state <= MDU_IDLE;
            end
            default: state <= MDU_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/pipe_controller.sv
// pipe_controller: five-stage MIPS control unit. Combinational decode in D,
// registered control fields through E, M and W with stall/flush on E.
// Ports: clk, reset (async, active-high), bus (pipe_controller_if.slave).
// Build option: PIPE_CONTROLLER_MDU_EN enables MULT/DIV/MFHI/MFLO decode and
// the mdu_seq sequencer; otherwise those encodings are illegal and the MDU
// outputs are tied to 0.
module pipe_controller
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned ALUCTRL_W = 4,
   parameter int unsigned MDU_LAT   = 4
) (
   input  logic               clk,
   input  logic               reset,
   pipe_controller_if.slave   bus
);
   if (MDU_LAT < 2 || ALUCTRL_W < 4) begin : g_cfg_check
      $error("pipe_controller: MDU_LAT must be >= 2 and ALUCTRL_W >= 4");
   end

   ctrl_e_t    dec;
   ctrl_e_t    e_q;
   logic [1:0] branch;
   logic [2:0] jump;
   logic       immext;
   logic       illegal;
   logic       regwrite_m, memtoreg_m, memwrite_m;
   logic       regwrite_w, memtoreg_w;
`ifdef PIPE_CONTROLLER_MDU_EN
   logic       mdu_d;
`endif

   // Decode
   always_comb begin
      dec     = '0;
      branch  = '0;
      jump    = '0;
      immext  = 1'b0;
      illegal = 1'b0;
`ifdef PIPE_CONTROLLER_MDU_EN
      mdu_d   = 1'b0;
`endif
      case (bus.opD)
         OP_RTYPE: begin
            dec.regwrite = 1'b1;
            dec.regdst   = 1'b1;
            case (bus.functD)
               FN_ADD: dec.alu = ALU_ADD;
               FN_SUB: dec.alu = ALU_SUB;
               FN_AND: dec.alu = ALU_AND;
               FN_OR:  dec.alu = ALU_OR;
               FN_XOR: dec.alu = ALU_XOR;
               FN_NOR: dec.alu = ALU_NOR;
               FN_SLT: dec.alu = ALU_SLT;
               FN_SLL: dec.alu = ALU_SLL;
               FN_SRL: dec.alu = ALU_SRL;
               FN_JR: begin
                  dec.regwrite = 1'b0;
                  dec.regdst   = 1'b0;
                  jump         = 3'b010;
               end
`ifdef PIPE_CONTROLLER_MDU_EN
               FN_MFHI: begin
                  dec.hiloread = 2'b10;
                  mdu_d        = 1'b1;
               end
               FN_MFLO: begin
                  dec.hiloread = 2'b01;
                  mdu_d        = 1'b1;
               end
               FN_MULT, FN_DIV: begin
                  dec.regwrite = 1'b0;
                  dec.regdst   = 1'b0;
                  dec.mdustart = 1'b1;
                  dec.mduop    = (bus.functD == FN_DIV);
                  mdu_d        = 1'b1;
               end
`endif
               default: illegal = 1'b1;
            endcase
         end
         OP_J:    jump = 3'b001;
         OP_JAL: begin
            jump         = 3'b100;
            dec.regwrite = 1'b1;
         end
         OP_LW: begin
            dec.alusrc   = 1'b1;
            dec.regwrite = 1'b1;
            dec.memtoreg = 1'b1;
            dec.alu      = ALU_ADD;
         end
         OP_SW: begin
            dec.alusrc   = 1'b1;
            dec.memwrite = 1'b1;
            dec.alu      = ALU_ADD;
         end
         OP_BEQ: begin
            branch  = 2'b10;
            dec.alu = ALU_SUB;
         end
         OP_BNE: begin
            branch  = 2'b01;
            dec.alu = ALU_SUB;
         end
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            dec.alusrc   = 1'b1;
            dec.regwrite = 1'b1;
            case (bus.opD)
               OP_ADDI: dec.alu = ALU_ADD;
               OP_SLTI: dec.alu = ALU_SLT;
               OP_ANDI: dec.alu = ALU_AND;
               OP_ORI:  dec.alu = ALU_OR;
               OP_XORI: dec.alu = ALU_XOR;
               default: dec.alu = ALU_LUI;
            endcase
            // Logical immediates zero-extend; the rest sign-extend
            immext = (bus.opD == OP_ANDI) || (bus.opD == OP_ORI) || (bus.opD == OP_XORI);
         end
         default: illegal = 1'b1;
      endcase
      // Illegal or in-reset decode drives no control at all
      if (illegal || reset) begin
         dec    = '0;
         branch = '0;
         jump   = '0;
         immext = 1'b0;
`ifdef PIPE_CONTROLLER_MDU_EN
         mdu_d  = 1'b0;
`endif
      end
   end

   assign bus.pcsrcD   = (branch[1] & bus.equalD) | (branch[0] & ~bus.equalD);
   assign bus.branchD  = branch;
   assign bus.jumpD    = jump;
   assign bus.immextD  = immext;
   assign bus.illegalD = illegal & ~reset;

   // E register: flush beats stall beats load
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           e_q <= '0;
      else if (bus.flushE) e_q <= '0;
      else if (!bus.stallE) e_q <= dec;
   end

   // M register: a held E instruction must not advance twice, so M gets a bubble
   always_ff @(posedge clk or posedge reset) begin
      if (reset || bus.stallE) begin
         regwrite_m <= 1'b0;
         memtoreg_m <= 1'b0;
         memwrite_m <= 1'b0;
      end else begin
         regwrite_m <= e_q.regwrite;
         memtoreg_m <= e_q.memtoreg;
         memwrite_m <= e_q.memwrite;
      end
   end

   // W register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regwrite_w <= 1'b0;
         memtoreg_w <= 1'b0;
      end else begin
         regwrite_w <= regwrite_m;
         memtoreg_w <= memtoreg_m;
      end
   end

   assign bus.alusrcE     = e_q.alusrc;
   assign bus.regdstE     = e_q.regdst;
   assign bus.regwriteE   = e_q.regwrite;
   assign bus.memtoregE   = e_q.memtoreg;
   assign bus.alucontrolE = ALUCTRL_W'(e_q.alu);
   assign bus.regwriteM   = regwrite_m;
   assign bus.memtoregM   = memtoreg_m;
   assign bus.memwriteM   = memwrite_m;
   assign bus.regwriteW   = regwrite_w;
   assign bus.memtoregW   = memtoreg_w;

`ifdef PIPE_CONTROLLER_MDU_EN
   mdu_seq #(.MDU_LAT(MDU_LAT)) u_mdu (
      .clk        (clk),
      .reset      (reset),
      .start      (e_q.mdustart),
      .stall      (bus.stallE),
      .mdu_d      (mdu_d),
      .mdustall_c (bus.mdustallD)
   );
   assign bus.mdustartE = e_q.mdustart;
   assign bus.mduopE    = e_q.mduop;
   assign bus.hiloreadE = e_q.hiloread;
`else
   logic unused_mdu;
   assign unused_mdu    = ^{e_q.mdustart, e_q.mduop, e_q.hiloread};
   assign bus.mdustallD = 1'b0;
   assign bus.mdustartE = 1'b0;
   assign bus.mduopE    = 1'b0;
   assign bus.hiloreadE = 2'b00;
`endif

endmodule

// File: tb/tb_pipe_controller.sv
// Scoreboard bench for pipe_controller: each directed vector drives one cycle
// of inputs and queues the hand-computed outputs for that cycle; a monitor
// pops and compares on every falling edge.
module tb_pipe_controller;

   // Encodings
   localparam logic [5:0] R    = 6'b000000;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] BNE  = 6'b000101;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] XORI = 6'b001110;
   localparam logic [5:0] LUI  = 6'b001111;
   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] BAD  = 6'b111111;
   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_MULT = 6'b011000;
   localparam logic [5:0] F_DIV  = 6'b011010;
   localparam logic [5:0] F_MFHI = 6'b010000;
   localparam logic [5:0] F_MFLO = 6'b010010;
   localparam logic [5:0] F_BAD  = 6'b111111;

   // D = {pcsrc, branch[1:0], jump[2:0], immext, illegal, mdustall}
   localparam logic [8:0] D_0      = 9'b0_00_000_0_0_0;
   localparam logic [8:0] D_IMMZ   = 9'b0_00_000_1_0_0;
   localparam logic [8:0] D_ILL    = 9'b0_00_000_0_1_0;
   localparam logic [8:0] D_BEQ_T  = 9'b1_10_000_0_0_0;
   localparam logic [8:0] D_BNE_NT = 9'b0_01_000_0_0_0;
   localparam logic [8:0] D_BNE_T  = 9'b1_01_000_0_0_0;
   localparam logic [8:0] D_MST    = 9'b0_00_000_0_0_1;
   // E = {alusrc, regdst, regwrite, memtoreg, alu[3:0], mdustart, mduop, hilo[1:0]}
   localparam logic [11:0] E_0    = 12'b0000_0000_0000;
   localparam logic [11:0] E_ADDI = 12'b1010_0010_0000;
   localparam logic [11:0] E_XORI = 12'b1010_0011_0000;
   localparam logic [11:0] E_LUI  = 12'b1010_1001_0000;
   localparam logic [11:0] E_SLL  = 12'b0110_0100_0000;
   localparam logic [11:0] E_ADD  = 12'b0110_0010_0000;
   localparam logic [11:0] E_SW   = 12'b1000_0010_0000;
   localparam logic [11:0] E_LW   = 12'b1011_0010_0000;
   localparam logic [11:0] E_BR   = 12'b0000_0110_0000;
   localparam logic [11:0] E_MULT = 12'b0000_0000_1000;
   localparam logic [11:0] E_DIV  = 12'b0000_0000_1100;
   localparam logic [11:0] E_MFLO = 12'b0110_0000_0001;
   localparam logic [11:0] E_MFHI = 12'b0110_0000_0010;
   // M = {regwrite, memtoreg, memwrite}, W = {regwrite, memtoreg}
   localparam logic [2:0] M_0 = 3'b000, M_RW = 3'b100, M_SW = 3'b001, M_LW = 3'b110;
   localparam logic [1:0] W_0 = 2'b00, W_RW = 2'b10, W_LW = 2'b11;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   pipe_controller_if #(.ALUCTRL_W(4)) bus ();

   pipe_controller #(.ALUCTRL_W(4), .MDU_LAT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int         tag;
      logic [8:0]  d;
      logic [11:0] e;
      logic [2:0]  m;
      logic [1:0]  w;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Drive one cycle of inputs just after the rising edge and queue its expectation
   task automatic step(input int tag, input logic rst, input logic [5:0] op,
                       input logic [5:0] fn, input logic eq, input logic st,
                       input logic fl, input logic [8:0] d, input logic [11:0] e,
                       input logic [2:0] m, input logic [1:0] w);
      exp_t x;
      @(posedge clk);
      #1;
      reset      = rst;
      bus.opD    = op;
      bus.functD = fn;
      bus.equalD = eq;
      bus.stallE = st;
      bus.flushE = fl;
      x.tag = tag; x.d = d; x.e = e; x.m = m; x.w = w;
      sb.push_back(x);
   endtask

   // Monitor
   initial begin
      exp_t        x;
      logic [8:0]  ad;
      logic [11:0] ae;
      logic [2:0]  am;
      logic [1:0]  aw;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            x  = sb.pop_front();
            ad = {bus.pcsrcD, bus.branchD, bus.jumpD, bus.immextD, bus.illegalD, bus.mdustallD};
            ae = {bus.alusrcE, bus.regdstE, bus.regwriteE, bus.memtoregE, bus.alucontrolE[3:0],
                  bus.mdustartE, bus.mduopE, bus.hiloreadE};
            am = {bus.regwriteM, bus.memtoregM, bus.memwriteM};
            aw = {bus.regwriteW, bus.memtoregW};
            n_checks++;
            if (ad !== x.d || ae !== x.e || am !== x.m || aw !== x.w) begin
               n_fail++;
               $display("FAIL vec%0d: got d=%b e=%b m=%b w=%b, want d=%b e=%b m=%b w=%b",
                        x.tag, ad, ae, am, aw, x.d, x.e, x.m, x.w);
            end
         end
      end
   end

   initial begin
      bus.opD = BAD; bus.functD = F_BAD; bus.equalD = 1'b0;
      bus.stallE = 1'b0; bus.flushE = 1'b0;
      // tag rst op fn eq st fl | D E M W
      // reset holds everything at zero, even for legal/illegal decodes
      step( 0, 1, XORI, F_BAD, 0, 0, 0, D_0,      E_0,    M_0,  W_0);
      step( 1, 1, BAD,  F_BAD, 0, 0, 0, D_0,      E_0,    M_0,  W_0);
      // ADDI, XORI, LUI, SLL back-to-back
      step( 2, 0, ADDI, F_BAD, 0, 0, 0, D_0,      E_0,    M_0,  W_0);
      step( 3, 0, XORI, F_BAD, 0, 0, 0, D_IMMZ,   E_ADDI, M_0,  W_0);
      step( 4, 0, LUI,  F_BAD, 0, 0, 0, D_0,      E_XORI, M_RW, W_0);
      step( 5, 0, R,    F_SLL, 0, 0, 0, D_0,      E_LUI,  M_RW, W_RW);
      step( 6, 0, BAD,  F_BAD, 0, 0, 0, D_ILL,    E_SLL,  M_RW, W_RW);
      // branches
      step( 7, 0, BEQ,  F_BAD, 1, 0, 0, D_BEQ_T,  E_0,    M_RW, W_RW);
      step( 8, 0, BNE,  F_BAD, 1, 0, 0, D_BNE_NT, E_BR,   M_0,  W_RW);
      step( 9, 0, BNE,  F_BAD, 0, 0, 0, D_BNE_T,  E_BR,   M_0,  W_0);
      // SW held in E for two stall cycles
      step(10, 0, SW,   F_BAD, 0, 0, 0, D_0,      E_BR,   M_0,  W_0);
      step(11, 0, R,    F_ADD, 0, 1, 0, D_0,      E_SW,   M_0,  W_0);
      step(12, 0, R,    F_ADD, 0, 1, 0, D_0,      E_SW,   M_0,  W_0);
      step(13, 0, R,    F_ADD, 0, 0, 0, D_0,      E_SW,   M_0,  W_0);
      step(14, 0, BAD,  F_BAD, 0, 0, 0, D_ILL,    E_ADD,  M_SW, W_0);
      step(15, 0, BAD,  F_BAD, 0, 0, 0, D_ILL,    E_0,    M_RW, W_0);
      // flush+stall together: E clears and M takes a bubble
      step(16, 0, LW,   F_BAD, 0, 0, 0, D_0,      E_0,    M_0,  W_RW);
      step(17, 0, ADDI, F_BAD, 0, 1, 1, D_0,      E_LW,   M_0,  W_0);
      step(18, 0, BAD,  F_BAD, 0, 0, 0, D_ILL,    E_0,    M_0,  W_0);
      // flush alone: E clears but its current instruction still advances
      step(19, 0, LW,   F_BAD, 0, 0, 0, D_0,      E_0,    M_0,  W_0);
      step(20, 0, ADDI, F_BAD, 0, 0, 1, D_0,      E_LW,   M_0,  W_0);
      step(21, 0, R,    F_BAD, 0, 0, 0, D_ILL,    E_0,    M_LW, W_0);
      step(22, 0, BAD,  F_BAD, 0, 0, 0, D_ILL,    E_0,    M_0,  W_LW);
      // reset mid-stream discards the in-flight ADDI
      step(23, 0, ADDI, F_BAD, 0, 0, 0, D_0,      E_0,    M_0,  W_0);
      step(24, 1, XORI, F_BAD, 0, 0, 0, D_0,      E_0,    M_0,  W_0);
      step(25, 0, ADDI, F_BAD, 0, 0, 0, D_0,      E_0,    M_0,  W_0);
      step(26, 0, BAD,  F_BAD, 0, 0, 0, D_ILL,    E_ADDI, M_0,  W_0);
      step(27, 0, BAD,  F_BAD, 0, 0, 0, D_ILL,    E_0,    M_RW, W_0);
      step(28, 0, BAD,  F_BAD, 0, 0, 0, D_ILL,    E_0,    M_0,  W_RW);
`ifdef PIPE_CONTROLLER_MDU_EN
      // MULT then dependent MFLO: 3 stall cycles; hazard unit flushes E meanwhile
      step(30, 0, R,    F_MULT, 0, 0, 0, D_0,     E_0,    M_0,  W_0);
      step(31, 0, R,    F_MFLO, 0, 0, 1, D_MST,   E_MULT, M_0,  W_0);
      step(32, 0, R,    F_MFLO, 0, 0, 1, D_MST,   E_0,    M_0,  W_0);
      step(33, 0, R,    F_MFLO, 0, 0, 1, D_MST,   E_0,    M_0,  W_0);
      step(34, 0, R,    F_MFLO, 0, 0, 0, D_0,     E_0,    M_0,  W_0);
      step(35, 0, BAD,  F_BAD,  0, 0, 0, D_ILL,   E_MFLO, M_0,  W_0);
      step(36, 0, BAD,  F_BAD,  0, 0, 0, D_ILL,   E_0,    M_RW, W_0);
      step(37, 0, BAD,  F_BAD,  0, 0, 0, D_ILL,   E_0,    M_0,  W_RW);
      // reset mid-BUSY returns the sequencer to IDLE: no stall afterwards
      step(40, 0, R,    F_DIV,  0, 0, 0, D_0,     E_0,    M_0,  W_0);
      step(41, 0, R,    F_MFHI, 0, 0, 1, D_MST,   E_DIV,  M_0,  W_0);
      step(42, 1, R,    F_MFHI, 0, 0, 0, D_0,     E_0,    M_0,  W_0);
      step(43, 0, R,    F_MFHI, 0, 0, 0, D_0,     E_0,    M_0,  W_0);
      step(44, 0, BAD,  F_BAD,  0, 0, 0, D_ILL,   E_MFHI, M_0,  W_0);
      step(45, 0, BAD,  F_BAD,  0, 0, 0, D_ILL,   E_0,    M_RW, W_0);
      step(46, 0, BAD,  F_BAD,  0, 0, 0, D_ILL,   E_0,    M_0,  W_RW);
`else
      // without the MDU the four encodings are illegal and start nothing
      step(30, 0, R,    F_DIV,  0, 0, 0, D_ILL,   E_0,    M_0,  W_0);
      step(31, 0, R,    F_MFLO, 0, 0, 0, D_ILL,   E_0,    M_0,  W_0);
      step(32, 0, R,    F_MULT, 0, 0, 0, D_ILL,   E_0,    M_0,  W_0);
      step(33, 0, R,    F_MFHI, 0, 0, 0, D_ILL,   E_0,    M_0,  W_0);
      step(34, 0, BAD,  F_BAD,  0, 0, 0, D_ILL,   E_0,    M_0,  W_0);
`endif
      // allow the monitor to drain, bounded
      for (int i = 0; i < 8 && sb.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: got %0d pending entries, want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_controller.md
# pipe_controller

Second-generation control unit for the five-stage MIPS pipeline. Decodes the instruction in Decode, carries control fields through Execute, Memory and Writeback, and adds an extended ALU set, per-stage stall and flush, and a multi-cycle multiply/divide sequencer that raises its own Decode stall. Sits between the hazard unit and the datapath, replacing the single-rate controller.

## Interface
- `ALUCTRL_W`, default 4: width of `alucontrolE`; must be ≥4; bits above [3] are driven 0.
- `MDU_LAT`, default 4: Execute-to-result cycles for MULT/DIV; must be ≥2.
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high; clears every register.
- `opD`, `functD`, in, 6 each: opcode and funct fields of the Decode instruction.
- `equalD`, in, 1: register-compare result for branches.
- `stallE`, in, 1: hold the E register.
- `flushE`, in, 1: clear the E register.
- `pcsrcD`, out, 1: branch taken.
- `branchD`, out, 2: {beq, bne}.
- `jumpD`, out, 3: {jal, jr, j}.
- `immextD`, out, 1: zero-extend the immediate.
- `illegalD`, out, 1: the opcode/funct pair is unsupported.
- `mdustallD`, out, 1: hold F/D because a Multiply/Divide Unit (MDU) result is pending.
- `alusrcE`, `regdstE`, `regwriteE`, `memtoregE`, out, 1 each.
- `alucontrolE`, out, `ALUCTRL_W`.
- `mdustartE`, out, 1: start the MDU this cycle.
- `mduopE`, out, 1: 0 = MULT, 1 = DIV.
- `hiloreadE`, out, 2: 01 = MFLO, 10 = MFHI.
- `regwriteM`, `memtoregM`, `memwriteM`, out, 1 each.
- `regwriteW`, `memtoregW`, out, 1 each.

## Operation
- Decode is combinational and covers:
  - R-type ADD, SUB, AND, OR, XOR, NOR, SLT, SLL, SRL, JR, MFHI, MFLO, MULT, DIV.
  - J, JAL, LW, SW, BEQ, BNE, ADDI, ANDI, ORI, XORI, SLTI, LUI.
- Any other opcode/funct pair sets `illegalD`=1 and drives every control to 0. Illegal instructions never produce X.
- ALU codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, NOR 1000, LUI 1001.
- Immediate extension: ANDI, ORI and XORI set `immextD`=1; all other immediate instructions sign-extend.
- `pcsrcD` = (branchD[1] & equalD) | (branchD[0] & ~equalD).
- E register priority: `flushE` over `stallE` over normal load.
  - When `stallE`=1, the M register loads a bubble: `regwriteM`=0 and `memwriteM`=0.
- The M and W registers always advance.
- MDU sequencer has two states, IDLE and BUSY, and a down-counter `cnt` of width clog2(`MDU_LAT`+1).
  - IDLE→BUSY when `mdustartE`=1 and `stallE`=0; `cnt` loads `MDU_LAT`-1.
  - In BUSY, `cnt` decrements every cycle. BUSY→IDLE on the cycle `cnt` reaches 1.
  - In BUSY, `mdustallD`=1 if the D instruction is MULT, DIV, MFHI or MFLO. Otherwise `mdustallD`=0.
- The external hazard unit ORs `mdustallD` into its F/D stall and its E flush.
- A `flushE` while in BUSY does not abort the sequencer; an issued MDU operation always completes.

## Timing
- All outputs are 0 while `reset`=1 and on the first edge after release. The sequencer resets to IDLE with `cnt`=0.
- Reset asserted mid-MDU-operation returns the sequencer to IDLE at once; the pending result is discarded.
- Latency from a D instruction to its controls:
  - E fields: 1 edge.
  - M fields: 2 edges.
  - W fields: 3 edges.
  - Each `stallE` cycle adds one edge.
- MULT or DIV decoded in cycle t, with no stall, gives `mdustartE`=1 in cycle t+1.
- A dependent MFLO in D is held through cycle t+1+`MDU_LAT`-1 and enters E at t+1+`MDU_LAT`.
- `flushE` and `stallE` in the same cycle: E clears, M takes a bubble.

## Configuration
- `PIPE_CONTROLLER_MDU_EN` defined:
  - MULT, DIV, MFHI and MFLO decode as described.
  - The sequencer is instantiated.
- Not defined:
  - Those four encodings decode as illegal.
  - `mdustallD`, `mdustartE`, `mduopE` and `hiloreadE` are tied to 0.
  - The sequencer logic is absent.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - opcode and funct localparams;
  - the ALU code enum;
  - a packed struct `ctrl_e_t` with the E-stage fields.
- One sub-module, `mdu_seq`, contains the sequencer FSM and counter.
- The decoder stays inline. Stage registers use the existing resettable flops, with asynchronous reset.

## Test plan
- Reset: with `reset`=1 mid-stream, every output is 0 and the sequencer is IDLE; after release, decoding of the next instruction resumes.
- Issue ADDI, XORI, LUI, SLL back-to-back:
  - `alucontrolE` = 0010, 0011, 1001, 0100 on successive cycles.
  - `immextD` = 0, 1, 0, 0 in decode.
  - Each instruction's `regwriteW`=1 exactly 3 edges after its decode.
- BEQ with `equalD`=1 gives `pcsrcD`=1; BNE with `equalD`=1 gives `pcsrcD`=0; opcode 6'b111111 gives `illegalD`=1 and all other controls 0.
- SW with `stallE`=1 for 2 cycles: `alusrcE` is held for 2 cycles, `memwriteM` stays 0 for those 2 cycles, then pulses 1 exactly once.
- MULT then MFLO, `MDU_LAT`=4: `mdustartE`=1 once; `mdustallD`=1 for 3 cycles; then `hiloreadE`=01.
- Sequencer edge cases: a `flushE` mid-BUSY leaves `cnt` decrementing; reset mid-BUSY returns IDLE; with the macro undefined, DIV gives `illegalD`=1.
